// File: rtl/spmv_kernel_scheduler.sv
// Launch sequencer for the SpMV kernels: start-edge detection, row/nnz snapshot,
// round-robin dispatch over one command port, completion tracking and runtime counters.
module spmv_kernel_scheduler #(
   parameter int CONF_NUM_KERNEL = 4,
   parameter int KID_W = (CONF_NUM_KERNEL > 1) ? $clog2(CONF_NUM_KERNEL) : 1
) (
   input  logic                            aclk,
   input  logic                            aresetn,
   input  logic [32*3*CONF_NUM_KERNEL-1:0] config_wire,
   output logic                            cmd_valid,
   input  logic                            cmd_ready,
   output logic [KID_W-1:0]                cmd_kid,
   output logic [31:0]                     cmd_row,
   output logic [31:0]                     cmd_nnz,
   input  logic [CONF_NUM_KERNEL-1:0]      kernel_done,
   output logic [CONF_NUM_KERNEL-1:0]      done_pulse,
   output logic [32*CONF_NUM_KERNEL-1:0]   status_wire,
   output logic [32*CONF_NUM_KERNEL-1:0]   cycles_wire
);

   localparam int N = CONF_NUM_KERNEL;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PEND = 3'd1,
      ST_RUN  = 3'd2,
      ST_DONE = 3'd3,
      ST_ERR  = 3'd4
   } kstate_e;

   kstate_e          state_q [N];
   logic [31:0]      row_q [N];
   logic [31:0]      nnz_q [N];
   logic [N-1:0]     start_q;
   logic [N-1:0]     done_pulse_q;
   logic [KID_W-1:0] rr_q;
   logic             cmd_valid_q;
   logic [KID_W-1:0] cmd_kid_q;
   logic [31:0]      cmd_row_q;
   logic [31:0]      cmd_nnz_q;

   logic [N-1:0]     start_now;
   logic [N-1:0]     accept;
   logic [31:0]      cfg_row [N];
   logic [31:0]      cfg_nnz [N];
   logic             grant_vld_d;
   logic [KID_W-1:0] grant_kid_d;

   // Per-kernel config decode, status/runtime export and the saturating runtime counter.
   for (genvar g = 0; g < N; g++) begin : g_k
      logic [31:0] cyc_q;

      assign start_now[g] = config_wire[96*g];
      assign cfg_row[g]   = config_wire[96*g+32 +: 32];
      assign cfg_nnz[g]   = config_wire[96*g+64 +: 32];
      assign accept[g]    = start_now[g] & ~start_q[g] &
                            ((state_q[g] == ST_IDLE) || (state_q[g] == ST_DONE) ||
                             (state_q[g] == ST_ERR));

      assign status_wire[32*g +: 32] = {29'd0, 3'(state_q[g])};
      assign cycles_wire[32*g +: 32] = cyc_q;

      always_ff @(posedge aclk or negedge aresetn) begin
         if (!aresetn) begin
            cyc_q <= '0;
         end else if (accept[g]) begin
            cyc_q <= '0;
         end else if (((state_q[g] == ST_PEND) || (state_q[g] == ST_RUN)) &&
                      (cyc_q != 32'hFFFF_FFFF)) begin
            cyc_q <= cyc_q + 32'd1;
         end
      end
   end

   // Walk from the farthest candidate back to the nearest so the first PEND after rr_q wins.
   always_comb begin
      grant_vld_d = 1'b0;
      grant_kid_d = '0;
      for (int off = N; off >= 1; off--) begin
         if (state_q[(int'(rr_q) + off) % N] == ST_PEND) begin
            grant_vld_d = 1'b1;
            grant_kid_d = KID_W'((int'(rr_q) + off) % N);
         end
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         for (int i = 0; i < N; i++) begin
            state_q[i] <= ST_IDLE;
            row_q[i]   <= '0;
            nnz_q[i]   <= '0;
         end
         start_q      <= '0;
         done_pulse_q <= '0;
         rr_q         <= KID_W'(N - 1);
         cmd_valid_q  <= 1'b0;
         cmd_kid_q    <= '0;
         cmd_row_q    <= '0;
         cmd_nnz_q    <= '0;
      end else begin
         start_q      <= start_now;
         done_pulse_q <= '0;

         // Granting only while the port is idle gives the one-cycle bubble after each launch.
         if (cmd_valid_q && cmd_ready) begin
            cmd_valid_q <= 1'b0;
         end else if (!cmd_valid_q && grant_vld_d) begin
            cmd_valid_q <= 1'b1;
            cmd_kid_q   <= grant_kid_d;
            cmd_row_q   <= row_q[grant_kid_d];
            cmd_nnz_q   <= nnz_q[grant_kid_d];
            rr_q        <= grant_kid_d;
         end

         for (int i = 0; i < N; i++) begin
            case (state_q[i])
               ST_PEND: begin
                  if (cmd_valid_q && cmd_ready && (cmd_kid_q == KID_W'(i)))
                     state_q[i] <= ST_RUN;
               end
               ST_RUN: begin
                  if (kernel_done[i]) begin
                     state_q[i]      <= ST_DONE;
                     done_pulse_q[i] <= 1'b1;
                  end
               end
               default: begin
                  if (accept[i]) begin
                     row_q[i]   <= cfg_row[i];
                     nnz_q[i]   <= cfg_nnz[i];
                     state_q[i] <= ((cfg_row[i] != 32'd0) && (cfg_nnz[i] != 32'd0)) ?
                                   ST_PEND : ST_ERR;
                  end
               end
            endcase
         end
      end
   end

   assign cmd_valid  = cmd_valid_q;
   assign cmd_kid    = cmd_kid_q;
   assign cmd_row    = cmd_row_q;
   assign cmd_nnz    = cmd_nnz_q;
   assign done_pulse = done_pulse_q;

endmodule

// File: tb/tb_spmv_kernel_scheduler.sv
// Directed bench for spmv_kernel_scheduler: launch timing, round robin, backpressure,
// error/ignored starts, async reset and counter saturation.
module tb_spmv_kernel_scheduler;

   localparam int N     = 4;
   localparam int KID_W = 2;
   localparam int W     = KID_W + 64;

   logic               aclk;
   logic               aresetn;
   logic [32*3*N-1:0]  config_wire;
   logic               cmd_valid;
   logic               cmd_ready;
   logic [KID_W-1:0]   cmd_kid;
   logic [31:0]        cmd_row;
   logic [31:0]        cmd_nnz;
   logic [N-1:0]       kernel_done;
   logic [N-1:0]       done_pulse;
   logic [32*N-1:0]    status_wire;
   logic [32*N-1:0]    cycles_wire;

   logic [W-1:0] exp_q[$];
   int errors = 0;
   int checks = 0;

   spmv_kernel_scheduler #(.CONF_NUM_KERNEL(N)) dut (
      .aclk        (aclk),
      .aresetn     (aresetn),
      .config_wire (config_wire),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_kid     (cmd_kid),
      .cmd_row     (cmd_row),
      .cmd_nnz     (cmd_nnz),
      .kernel_done (kernel_done),
      .done_pulse  (done_pulse),
      .status_wire (status_wire),
      .cycles_wire (cycles_wire)
   );

   // Clock and watchdog
   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1, "watchdog");
   end

   // Driver tasks
   task automatic tick(input int n = 1);
      repeat (n) @(posedge aclk);
      #1;
   endtask

   task automatic set_start(input int k, input logic v);
      config_wire[96*k] = v;
   endtask

   task automatic set_cfg(input int k, input logic [31:0] r, input logic [31:0] n);
      config_wire[96*k+32 +: 32] = r;
      config_wire[96*k+64 +: 32] = n;
   endtask

   function automatic logic [31:0] status(input int k);
      return status_wire[32*k +: 32];
   endfunction

   function automatic logic [31:0] cycles(input int k);
      return cycles_wire[32*k +: 32];
   endfunction

   // Scoreboard
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_cmd(input logic [KID_W-1:0] kid, input logic [31:0] r, input logic [31:0] n);
      exp_q.push_back({kid, r, n});
   endtask

   task automatic check_cmd(input string tag);
      logic [W-1:0] e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s: observed=command expected=empty queue", tag);
      end else begin
         e = exp_q.pop_front();
         chk({tag, "_valid"}, 32'(cmd_valid), 32'd1);
         chk({tag, "_kid"}, 32'(cmd_kid), 32'(e[W-1 -: KID_W]));
         chk({tag, "_row"}, cmd_row, e[63:32]);
         chk({tag, "_nnz"}, cmd_nnz, e[31:0]);
      end
   endtask

   initial begin
      aresetn     = 1'b0;
      config_wire = '0;
      cmd_ready   = 1'b0;
      kernel_done = '0;
      tick(2);

      chk("rst_valid", 32'(cmd_valid), 32'd0);
      chk("rst_kid", 32'(cmd_kid), 32'd0);
      chk("rst_row", cmd_row, 32'd0);
      chk("rst_nnz", cmd_nnz, 32'd0);
      chk("rst_pulse", 32'(done_pulse), 32'd0);
      for (int k = 0; k < N; k++) begin
         chk("rst_status", status(k), 32'd0);
         chk("rst_cycles", cycles(k), 32'd0);
      end
      aresetn = 1'b1;
      tick();

      // Single launch of kernel 0
      cmd_ready = 1'b1;
      set_cfg(0, 32'd8, 32'd20);
      set_start(0, 1'b1);
      tick();
      chk("s_pend", status(0), 32'd1);
      chk("s_valid_early", 32'(cmd_valid), 32'd0);
      push_cmd(2'd0, 32'd8, 32'd20);
      tick();
      check_cmd("s_cmd");
      tick();
      chk("s_run", status(0), 32'd2);
      chk("s_valid_low", 32'(cmd_valid), 32'd0);
      tick(9);
      kernel_done[0] = 1'b1;
      tick();
      kernel_done[0] = 1'b0;
      chk("s_done", status(0), 32'd3);
      chk("s_pulse", 32'(done_pulse), 32'h1);
      chk("s_cycles", cycles(0), 32'd12);
      tick();
      chk("s_pulse_off", 32'(done_pulse), 32'd0);
      chk("s_cycles_hold", cycles(0), 32'd12);
      chk("s_done_hold", status(0), 32'd3);

      // Zero row count goes to ERR without a command
      set_cfg(2, 32'd0, 32'd5);
      set_start(2, 1'b1);
      tick();
      chk("e_err", status(2), 32'd4);
      chk("e_cycles", cycles(2), 32'd0);
      tick();
      chk("e_nocmd", 32'(cmd_valid), 32'd0);
      chk("e_err_hold", status(2), 32'd4);

      // Asynchronous reset while one kernel runs and another waits on the port
      set_start(0, 1'b0);
      set_start(2, 1'b0);
      set_cfg(1, 32'd3, 32'd4);
      set_start(1, 1'b1);
      tick();
      push_cmd(2'd1, 32'd3, 32'd4);
      tick();
      check_cmd("r_cmd");
      tick();
      chk("r_run", status(1), 32'd2);
      cmd_ready = 1'b0;
      set_cfg(3, 32'd2, 32'd2);
      set_start(3, 1'b1);
      tick(2);
      chk("r_held_valid", 32'(cmd_valid), 32'd1);
      chk("r_held_kid", 32'(cmd_kid), 32'd3);
      #2;
      aresetn = 1'b0;
      #1;
      chk("ar_valid", 32'(cmd_valid), 32'd0);
      chk("ar_kid", 32'(cmd_kid), 32'd0);
      chk("ar_pulse", 32'(done_pulse), 32'd0);
      for (int k = 0; k < N; k++) begin
         chk("ar_status", status(k), 32'd0);
         chk("ar_cycles", cycles(k), 32'd0);
      end
      config_wire = '0;
      tick();
      aresetn = 1'b1;
      tick();

      // Round robin: all four start together
      cmd_ready = 1'b1;
      for (int k = 0; k < N; k++) begin
         set_cfg(k, 32'(k + 1), 32'(16 + k));
         set_start(k, 1'b1);
      end
      tick();
      chk("rr1_pend3", status(3), 32'd1);
      for (int k = 0; k < N; k++) push_cmd(KID_W'(k), 32'(k + 1), 32'(16 + k));
      tick();
      for (int k = 0; k < N; k++) begin
         check_cmd("rr1");
         tick();
         chk("rr1_gap", 32'(cmd_valid), 32'd0);
         tick();
      end
      for (int k = 0; k < N; k++) chk("rr1_run", status(k), 32'd2);
      kernel_done = 4'hF;
      tick();
      kernel_done = '0;
      chk("rr1_pulse", 32'(done_pulse), 32'hF);
      for (int k = 0; k < N; k++) chk("rr1_done", status(k), 32'd3);

      // Restart from DONE; pointer continues after kernel 3
      for (int k = 0; k < N; k++) begin
         set_start(k, 1'b0);
         set_cfg(k, 32'(k + 5), 32'(32 + k));
      end
      tick();
      for (int k = 0; k < N; k++) set_start(k, 1'b1);
      tick();
      chk("rr2_clr", cycles(0), 32'd0);
      chk("rr2_pend2", status(2), 32'd1);
      for (int k = 0; k < N; k++) push_cmd(KID_W'(k), 32'(k + 5), 32'(32 + k));
      kernel_done = 4'b0100;
      tick();
      kernel_done = '0;
      chk("rr2_stray_done", status(2), 32'd1);
      chk("rr2_stray_pulse", 32'(done_pulse), 32'd0);
      for (int k = 0; k < N; k++) begin
         check_cmd("rr2");
         tick();
         chk("rr2_gap", 32'(cmd_valid), 32'd0);
         tick();
      end

      // Backpressure with a competing start and a config rewrite
      kernel_done = 4'hF;
      tick();
      kernel_done = '0;
      for (int k = 0; k < N; k++) set_start(k, 1'b0);
      tick();
      cmd_ready = 1'b0;
      set_cfg(0, 32'd7, 32'd9);
      set_start(0, 1'b1);
      tick(2);
      for (int c = 0; c < 5; c++) begin
         chk("bp_valid", 32'(cmd_valid), 32'd1);
         chk("bp_kid", 32'(cmd_kid), 32'd0);
         chk("bp_row", cmd_row, 32'd7);
         chk("bp_nnz", cmd_nnz, 32'd9);
         if (c == 1) begin
            set_cfg(1, 32'd11, 32'd12);
            set_start(1, 1'b1);
            set_cfg(0, 32'd99, 32'd98);
         end
         tick();
      end
      chk("bp_k1_pend", status(1), 32'd1);
      push_cmd(2'd0, 32'd7, 32'd9);
      cmd_ready = 1'b1;
      check_cmd("bp_k0");
      tick();
      chk("bp_gap", 32'(cmd_valid), 32'd0);
      chk("bp_k0_run", status(0), 32'd2);
      push_cmd(2'd1, 32'd11, 32'd12);
      tick();
      check_cmd("bp_k1");
      tick();
      chk("bp_k1_run", status(1), 32'd2);

      // Rising edge while RUN is ignored
      set_start(0, 1'b0);
      tick();
      set_start(0, 1'b1);
      tick();
      chk("ig_run", status(0), 32'd2);
      chk("ig_cycles", cycles(0), 32'd11);
      chk("ig_valid", 32'(cmd_valid), 32'd0);

      // Done and start edge in the same cycle: done wins
      set_start(0, 1'b0);
      tick();
      set_start(0, 1'b1);
      kernel_done[0] = 1'b1;
      tick();
      kernel_done[0] = 1'b0;
      chk("sim_done", status(0), 32'd3);
      chk("sim_pulse", 32'(done_pulse), 32'h1);
      chk("sim_cycles", cycles(0), 32'd13);
      chk("sim_valid", 32'(cmd_valid), 32'd0);

      // Counter saturation on kernel 1, which is still running
      force dut.g_k[1].cyc_q = 32'hFFFF_FFFD;
      #1;
      release dut.g_k[1].cyc_q;
      tick();
      chk("sat_fffe", cycles(1), 32'hFFFF_FFFE);
      tick();
      chk("sat_ffff", cycles(1), 32'hFFFF_FFFF);
      tick();
      chk("sat_hold", cycles(1), 32'hFFFF_FFFF);
      kernel_done[1] = 1'b1;
      tick();
      kernel_done[1] = 1'b0;
      chk("sat_done", status(1), 32'd3);
      chk("sat_final", cycles(1), 32'hFFFF_FFFF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
